// File: rtl/fifo_frame_pkg.sv
// rtl/fifo_frame_pkg.sv - shared constants for the FIFO frame packer
package fifo_frame_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_HDR  = 3'd1;
    localparam state_t ST_SEQ  = 3'd2;
    localparam state_t ST_PAY  = 3'd3;
    localparam state_t ST_CHK  = 3'd4;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
    localparam int         CHK_W          = 8;

endpackage

// File: rtl/frame_checksum.sv
// rtl/frame_checksum.sv - modulo-256 running sum of the bytes of one frame
module frame_checksum
    import fifo_frame_pkg::*;
(
    input  logic             read_clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             add,
    input  logic [CHK_W-1:0] data_byte,
    output logic [CHK_W-1:0] sum
);

    // Accumulate each byte as it enters the output register; clear wins over add.
    always_ff @(posedge read_clk) begin
        if (!reset || clear) begin
            sum <= '0;
        end else if (add) begin
            sum <= sum + data_byte;
        end
    end

endmodule

// File: rtl/fifo_frame_packer.sv
// rtl/fifo_frame_packer.sv - pops FIFO words and emits header/seq/payload/checksum frames
module fifo_frame_packer
    import fifo_frame_pkg::*;
#(
    parameter int         FRAME_LEN = 4,
    parameter logic [7:0] HEADER    = HEADER_DEFAULT
) (
    input  logic        read_clk,
    input  logic        reset,
    input  logic [7:0]  fifo_data,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [7:0]  frame_data,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic        frame_last,
    output logic [15:0] frame_count
);

    localparam logic [7:0] LEN8 = 8'(FRAME_LEN);

    state_t           state;
    logic [7:0]       seq;
    logic [7:0]       pay_cnt;
    logic [CHK_W-1:0] sum;
    logic             slot_free;
    logic             cs_clear;
    logic             cs_add;
    logic [CHK_W-1:0] cs_byte;

    // The output register may take a new byte when empty or being drained this edge.
    assign slot_free  = !frame_valid || frame_ready;
    assign fifo_rd_en = ((state == ST_SEQ) || (state == ST_PAY)) && slot_free
                        && !fifo_empty && (pay_cnt < LEN8);

    // Feed the checksum with the seq byte and every popped payload byte.
    always_comb begin
        cs_add   = 1'b0;
        cs_byte  = fifo_data;
        cs_clear = 1'b0;
        if ((state == ST_HDR) && slot_free) begin
            cs_add  = 1'b1;
            cs_byte = seq;
        end else if (fifo_rd_en) begin
            cs_add = 1'b1;
        end
        if ((state == ST_CHK) && frame_valid && frame_ready) begin
            cs_clear = 1'b1;
        end
    end

    frame_checksum u_checksum (
        .read_clk  (read_clk),
        .reset     (reset),
        .clear     (cs_clear),
        .add       (cs_add),
        .data_byte (cs_byte),
        .sum       (sum)
    );

    // Frame sequencer and output register; nothing loads unless the slot is free.
    always_ff @(posedge read_clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            frame_data  <= 8'h00;
            frame_valid <= 1'b0;
            frame_last  <= 1'b0;
            frame_count <= 16'h0000;
            seq         <= 8'h00;
            pay_cnt     <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (slot_free) begin
                        if (!fifo_empty) begin
                            frame_data  <= HEADER;
                            frame_valid <= 1'b1;
                            frame_last  <= 1'b0;
                            pay_cnt     <= 8'h00;
                            state       <= ST_HDR;
                        end else begin
                            frame_valid <= 1'b0;
                        end
                    end
                end
                ST_HDR: begin
                    if (slot_free) begin
                        frame_data  <= seq;
                        frame_valid <= 1'b1;
                        state       <= ST_SEQ;
                    end
                end
                ST_SEQ: begin
                    if (fifo_rd_en) begin
                        frame_data  <= fifo_data;
                        frame_valid <= 1'b1;
                        pay_cnt     <= 8'h01;
                        state       <= ST_PAY;
                    end else if (slot_free) begin
                        frame_valid <= 1'b0;
                    end
                end
                ST_PAY: begin
                    if (slot_free && (pay_cnt == LEN8)) begin
                        frame_data  <= sum;
                        frame_valid <= 1'b1;
                        frame_last  <= 1'b1;
                        state       <= ST_CHK;
                    end else if (fifo_rd_en) begin
                        frame_data  <= fifo_data;
                        frame_valid <= 1'b1;
                        pay_cnt     <= pay_cnt + 8'h01;
                    end else if (slot_free) begin
                        frame_valid <= 1'b0;
                    end
                end
                ST_CHK: begin
                    // frame_valid is always set here, so a free slot means the checksum was taken.
                    if (slot_free) begin
                        frame_valid <= 1'b0;
                        frame_last  <= 1'b0;
                        frame_count <= frame_count + 16'h0001;
                        seq         <= seq + 8'h01;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_frame_packer.sv
// tb/tb_fifo_frame_packer.sv - scoreboard bench for fifo_frame_packer
module tb_fifo_frame_packer;

    localparam int FRAME_LEN = 4;

    logic        read_clk = 1'b0;
    logic        reset;
    logic [7:0]  fifo_data;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  frame_data;
    logic        frame_valid;
    logic        frame_ready;
    logic        frame_last;
    logic [15:0] frame_count;

    fifo_frame_packer #(.FRAME_LEN(FRAME_LEN), .HEADER(8'hA5)) dut (
        .read_clk    (read_clk),
        .reset       (reset),
        .fifo_data   (fifo_data),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_last  (frame_last),
        .frame_count (frame_count)
    );

    always #5 read_clk = ~read_clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] fq[$];
    logic [8:0] exp_q[$];
    logic [7:0] seq_m;
    int         fcount_m;
    int         rd_cnt;
    int         acc_cnt;
    logic       ready_drv;
    logic       stalled;
    logic [8:0] stall_word;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_frame(input logic [31:0] pl);
        logic [7:0] s;
        logic [7:0] b;
        s = seq_m;
        exp_q.push_back({1'b0, 8'hA5});
        exp_q.push_back({1'b0, seq_m});
        for (int i = 0; i < FRAME_LEN; i++) begin
            b = pl[31-8*i -: 8];
            exp_q.push_back({1'b0, b});
            s = s + b;
        end
        exp_q.push_back({1'b1, s});
        seq_m = seq_m + 8'h01;
    endtask

    task automatic feed(input logic [31:0] pl);
        for (int i = 0; i < FRAME_LEN; i++) fq.push_back(pl[31-8*i -: 8]);
    endtask

    task automatic step();
        logic [8:0] e;
        @(negedge read_clk);
        frame_ready = ready_drv;
        fifo_empty  = (fq.size() == 0);
        fifo_data   = (fq.size() != 0) ? fq[0] : 8'h00;
        #1;
        if (stalled) check("hold", 32'({frame_valid, frame_last, frame_data}), 32'({1'b1, stall_word}));
        stalled    = frame_valid && !frame_ready && reset;
        stall_word = {frame_last, frame_data};
        if (fifo_empty) check("rd_en_empty", 32'(fifo_rd_en), 32'd0);
        if (fifo_rd_en && !fifo_empty) begin
            void'(fq.pop_front());
            rd_cnt++;
        end
        if (frame_valid && frame_ready && reset) begin
            acc_cnt++;
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("byte", 32'({frame_last, frame_data}), 32'(e));
                if (e[8]) fcount_m++;
            end
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || frame_valid) && n < budget) begin
            step();
            n++;
        end
        check("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_acc(input int target, input int budget);
        int n;
        n = 0;
        while (acc_cnt < target && n < budget) begin
            step();
            n++;
        end
        check("wait_acc", 32'(acc_cnt), 32'(target));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(frame_valid), 32'd0);
        check({tag, "_last"},  32'(frame_last),  32'd0);
        check({tag, "_data"},  32'(frame_data),  32'd0);
        check({tag, "_count"}, 32'(frame_count), 32'd0);
        check({tag, "_rd_en"}, 32'(fifo_rd_en),  32'd0);
    endtask

    initial begin
        int n;
        int base;
        reset = 1'b0; ready_drv = 1'b1; frame_ready = 1'b1;
        fifo_empty = 1'b1; fifo_data = 8'h00;
        seq_m = 8'h00; fcount_m = 0; rd_cnt = 0; acc_cnt = 0; stalled = 1'b0; stall_word = '0;

        step(); step();
        check_reset_outputs("rst");
        reset = 1'b1;

        // FIFO empty for 100 cycles
        repeat (100) begin
            step();
            check("idle_valid", 32'(frame_valid), 32'd0);
        end

        // basic frame
        rd_cnt = 0;
        exp_frame(32'h16171819);
        feed(32'h16171819);
        drain(50);
        check("t1_rd_pulses", 32'(rd_cnt), 32'd4);
        check("t1_count", 32'(frame_count), 32'd1);

        // back-pressure on the header
        ready_drv = 1'b0;
        rd_cnt = 0;
        exp_frame(32'h16171819);
        feed(32'h16171819);
        n = 0;
        while (!frame_valid && n < 20) begin
            step();
            n++;
        end
        check("t2_hdr_valid", 32'(frame_valid), 32'd1);
        check("t2_hdr_data", 32'(frame_data), 32'hA5);
        repeat (2) begin
            step();
            check("t2_hdr_data", 32'(frame_data), 32'hA5);
        end
        check("t2_no_rd", 32'(rd_cnt), 32'd0);
        ready_drv = 1'b1;
        drain(50);
        check("t2_rd_pulses", 32'(rd_cnt), 32'd4);
        check("t2_count", 32'(frame_count), 32'd2);

        // FIFO runs dry mid-payload
        exp_frame(32'h16171819);
        fq.push_back(8'h16);
        fq.push_back(8'h17);
        wait_acc(acc_cnt + 4, 50);
        repeat (5) begin
            step();
            check("t3_gap_valid", 32'(frame_valid), 32'd0);
        end
        fq.push_back(8'h18);
        fq.push_back(8'h19);
        drain(50);
        check("t3_count", 32'(frame_count), 32'(fcount_m));

        // reset while payload byte 2 is presented
        exp_frame(32'h01020304);
        feed(32'h01020304);
        base = acc_cnt;
        wait_acc(base + 3, 50);
        step();
        reset = 1'b0;
        fq.delete();
        exp_q.delete();
        seq_m = 8'h00;
        fcount_m = 0;
        exp_frame(32'hA1B2C3D4);
        feed(32'hA1B2C3D4);
        step();
        check_reset_outputs("t5");
        reset = 1'b1;
        drain(50);
        check("t5_count", 32'(frame_count), 32'd1);

        // 257 all-zero frames: seq wraps FF -> 00
        reset = 1'b0;
        step();
        reset = 1'b1;
        fq.delete();
        exp_q.delete();
        seq_m = 8'h00;
        fcount_m = 0;
        repeat (257) begin
            exp_frame(32'h00000000);
            feed(32'h00000000);
        end
        drain(3000);
        check("t4_count", 32'(frame_count), 32'd257);
        check("t4_model_count", 32'(fcount_m), 32'd257);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_frame_packer.md
# fifo_frame_packer

Read-side consumer of the asynchronous FIFO, running entirely in the read clock domain. Pops 8-bit words from the FIFO's show-ahead read port and emits them as framed packets on a valid/ready byte stream. Each packet is a header byte, a sequence byte, FRAME_LEN payload bytes and a checksum byte. The block stalls cleanly on FIFO-empty and on downstream back-pressure.

## Interface
Parameters:
- FRAME_LEN, 4: payload bytes per frame; legal range 1..255.
- HEADER, 8'hA5: constant first byte of every frame.

Ports:
- read_clk  input  1  sole clock; same clock as the FIFO read side.
- reset  input  1  synchronous, active-low reset: sampled on the rising edge of read_clk; 0 = reset.
- fifo_data  input  8  FIFO head word (show-ahead); valid whenever fifo_empty=0.
- fifo_empty  input  1  FIFO read_empty flag.
- fifo_rd_en  output  1  pop strobe; combinational; FIFO advances on the same read_clk edge.
- frame_data  output  8  registered output byte.
- frame_valid  output  1  frame_data is valid.
- frame_ready  input  1  downstream accepts the byte on an edge where frame_valid=1 and frame_ready=1.
- frame_last  output  1  high with the checksum byte only.
- frame_count  output  16  count of completed frames; wraps at 2^16.

## Operation
- States:
  - IDLE
  - HDR: header loaded or being presented.
  - SEQ
  - PAY
  - CHK
- Output register "slot free" = !frame_valid || frame_ready. The register loads only when the slot is free. If the slot is free and nothing is loaded, frame_valid drops to 0.
- IDLE → HDR when fifo_empty=0 and the slot is free. On that edge, load HEADER.
- HDR → SEQ when the slot is free. On that edge, load the current seq.
- SEQ → PAY when the slot is free and fifo_empty=0. On that edge:
  - load fifo_data;
  - assert fifo_rd_en;
  - set pay_cnt=1.
- If fifo_empty=1, remain in SEQ with frame_valid falling once the seq byte is accepted.
- PAY: on each edge where the slot is free and fifo_empty=0:
  - assert fifo_rd_en;
  - load fifo_data;
  - increment pay_cnt.
- PAY → CHK when the slot is free and pay_cnt==FRAME_LEN. On that edge, load the checksum with frame_last=1.
- CHK → IDLE when the checksum byte is accepted. On that edge:
  - frame_count += 1;
  - seq += 1 (8-bit, wraps 8'hFF→8'h00);
  - checksum clears.
- fifo_rd_en = (state∈{SEQ,PAY}) && slot free && !fifo_empty && pay_cnt<FRAME_LEN. It is never asserted when fifo_empty=1.
- Checksum rules:
  - 8-bit modulo-256 sum of the seq byte and all payload bytes; the header is excluded.
  - The accumulator adds each byte as it is loaded into the output register.
- Reset mid-frame:
  - the partial frame is abandoned with no checksum byte;
  - seq is reset to 0;
  - popped data is lost, and the FIFO is not rewound.

## Timing
- Reset values:
  - frame_valid=0, frame_last=0, frame_data=8'h00;
  - fifo_rd_en=0 (state IDLE);
  - frame_count=0, seq=0, checksum=0.
- Latency: with fifo_empty falling at edge N while in IDLE with the slot free, the header is valid after edge N+1.
- Throughput with frame_ready held high: one byte per cycle. A frame takes FRAME_LEN+3 cycles. One IDLE cycle separates frames.
- frame_data and frame_last are stable while frame_valid=1 and frame_ready=0.
- fifo_rd_en is combinational from registered state plus fifo_empty and frame_ready. No combinational path from fifo_data to any output.

## Structure
- Shared package fifo_frame_pkg:
  - state enum {IDLE,HDR,SEQ,PAY,CHK};
  - HEADER default constant;
  - checksum width constant (8).
- Single module. Optional sub-module frame_checksum: holds the accumulator, with inputs clear/add/byte and output sum.
- No clock-domain logic here; all synchronisation stays in the FIFO.

## Test plan
- FIFO holds 8'h16,17,18,19 (FRAME_LEN=4, seq=0), frame_ready=1 → stream A5,00,16,17,18,19,5E; frame_last only on 5E; frame_count=1; exactly 4 fifo_rd_en pulses.
- Same data, frame_ready low for 3 cycles while the header is valid → A5 held stable for 3 cycles, no fifo_rd_en, then the stream completes unchanged.
- Only 8'h16,17 present, then FIFO empty for 5 cycles, then 18,19 arrive:
  - frame_valid drops after 17 is accepted;
  - fifo_rd_en stays 0 while empty;
  - the frame resumes and the checksum is still 5E.
- Run 257 frames of all-zero payload → seq byte of frame 256 is FF with checksum FF; frame 257 has seq 00 and checksum 00; frame_count=257.
- Assert reset (reset=0) during the PAY byte 2 cycle:
  - next cycle all outputs are at reset values and fifo_rd_en=0;
  - the next frame starts with A5,00.
- fifo_empty=1 continuously for 100 cycles after reset → frame_valid=0 and fifo_rd_en=0 throughout.
